// File: rtl/dcache_bank_arb_if.sv
// Bundles the read ports, the two write ports and the bank-side SRAM controls of the
// data-cache bank arbiter, so they can be passed around as a single port.
interface dcache_bank_arb_if #(
  parameter int NumPorts  = 3,
  parameter int NumBanks  = 2,
  parameter int IdxWidth  = 8,
  parameter int WordWidth = 64
);
  localparam int BW  = $clog2(NumBanks);
  localparam int BeW = WordWidth / 8;

  // Handshake: a requester holds *_req high with stable payload. The matching *_gnt is
  // combinational in that same cycle, and a grant means the request was accepted in that
  // cycle. Read data comes back one cycle later, and it comes with rd_rvalid.
  logic [NumPorts-1:0]                rd_req_i;
  logic [NumPorts-1:0]                rd_prio_i;
  logic [NumPorts-1:0][BW-1:0]        rd_bank_i;
  logic [NumPorts-1:0][IdxWidth-1:0]  rd_idx_i;
  logic [NumPorts-1:0]                rd_gnt_o;
  logic [NumPorts-1:0]                rd_rvalid_o;
  logic [NumPorts-1:0][WordWidth-1:0] rd_rdata_o;

  logic                               cl_wr_req_i;
  logic [IdxWidth-1:0]                cl_wr_idx_i;
  logic [NumBanks-1:0][WordWidth-1:0] cl_wr_data_i;
  logic                               cl_wr_gnt_o;

  logic                               wr_req_i;
  logic [BW-1:0]                      wr_bank_i;
  logic [IdxWidth-1:0]                wr_idx_i;
  logic [WordWidth-1:0]               wr_data_i;
  logic [BeW-1:0]                     wr_be_i;
  logic                               wr_gnt_o;

  logic [NumBanks-1:0]                bank_req_o;
  logic [NumBanks-1:0]                bank_we_o;
  logic [NumBanks-1:0][IdxWidth-1:0]  bank_idx_o;
  logic [NumBanks-1:0][WordWidth-1:0] bank_wdata_o;
  logic [NumBanks-1:0][BeW-1:0]       bank_be_o;
  logic [NumBanks-1:0][WordWidth-1:0] bank_rdata_i;

  modport slave (
    input  rd_req_i, rd_prio_i, rd_bank_i, rd_idx_i,
    output rd_gnt_o, rd_rvalid_o, rd_rdata_o,
    input  cl_wr_req_i, cl_wr_idx_i, cl_wr_data_i,
    output cl_wr_gnt_o,
    input  wr_req_i, wr_bank_i, wr_idx_i, wr_data_i, wr_be_i,
    output wr_gnt_o,
    output bank_req_o, bank_we_o, bank_idx_o, bank_wdata_o, bank_be_o,
    input  bank_rdata_i
  );

  modport master (
    output rd_req_i, rd_prio_i, rd_bank_i, rd_idx_i,
    input  rd_gnt_o, rd_rvalid_o, rd_rdata_o,
    output cl_wr_req_i, cl_wr_idx_i, cl_wr_data_i,
    input  cl_wr_gnt_o,
    output wr_req_i, wr_bank_i, wr_idx_i, wr_data_i, wr_be_i,
    input  wr_gnt_o,
    input  bank_req_o, bank_we_o, bank_idx_o, bank_wdata_o, bank_be_o,
    output bank_rdata_i
  );
endinterface

// File: rtl/dcache_bank_arb.sv
// Data-cache bank arbiter. Each bank picks one read winner round-robin, with priority and
// anti-starvation escalation, and same-index readers merge onto that winner.
module dcache_bank_arb #(
  parameter int NumPorts    = 3,
  parameter int NumBanks    = 2,
  parameter int IdxWidth    = 8,
  parameter int WordWidth   = 64,
  parameter int StarveLimit = 8
) (
  input logic               clk_i,
  input logic               rst_i,
  dcache_bank_arb_if.slave  bus
);
  localparam int BW  = $clog2(NumBanks);
  localparam int BeW = WordWidth / 8;
  localparam int PW  = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int CW  = $clog2(StarveLimit + 1);

  logic [NumBanks-1:0][PW-1:0]        ptr_q;
  logic [NumPorts-1:0][CW-1:0]        cnt_q;
  logic [CW-1:0]                      wr_cnt_q;
  logic [NumPorts-1:0]                rvalid_q;
  logic [NumPorts-1:0][BW-1:0]        rbank_q;

  logic [NumPorts-1:0]                starve, eff;
  logic                               wr_starve;
  logic [NumBanks-1:0][NumPorts-1:0]  req_b, cand;
  logic [NumBanks-1:0][PW-1:0]        win;
  logic [NumBanks-1:0]                bank_rd;
  logic [NumPorts-1:0]                rd_gnt;
  logic                               cl_gnt, wr_gnt;
  logic [NumBanks-1:0]                bank_req, bank_we;
  logic [NumBanks-1:0][IdxWidth-1:0]  bank_idx;
  logic [NumBanks-1:0][WordWidth-1:0] bank_wdata;
  logic [NumBanks-1:0][BeW-1:0]       bank_be;
  logic [NumPorts-1:0][WordWidth-1:0] rdata;

  // First candidate at or above the pointer, else wrap to the lowest candidate.
  function automatic logic [PW-1:0] rr_pick(input logic [NumPorts-1:0] c,
                                            input logic [PW-1:0] ptr);
    logic [PW-1:0] pick;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int p = 0; p < NumPorts; p++)
      if (!found && c[p] && PW'(p) >= ptr) begin
        pick  = PW'(p);
        found = 1'b1;
      end
    for (int p = 0; p < NumPorts; p++)
      if (!found && c[p]) begin
        pick  = PW'(p);
        found = 1'b1;
      end
    return pick;
  endfunction

  always_comb begin
    starve    = '0;
    req_b     = '0;
    cand      = '0;
    for (int p = 0; p < NumPorts; p++) starve[p] = (cnt_q[p] == CW'(StarveLimit));
    eff       = bus.rd_prio_i | starve;
    wr_starve = (wr_cnt_q == CW'(StarveLimit));
    for (int b = 0; b < NumBanks; b++) begin
      for (int p = 0; p < NumPorts; p++)
        req_b[b][p] = bus.rd_req_i[p] && (bus.rd_bank_i[p] == BW'(b));
      cand[b] = (|(req_b[b] & eff)) ? (req_b[b] & eff) : req_b[b];
    end
  end

  always_comb begin
    rd_gnt     = '0;
    cl_gnt     = 1'b0;
    wr_gnt     = 1'b0;
    win        = '0;
    bank_rd    = '0;
    bank_req   = '0;
    bank_we    = '0;
    bank_idx   = '0;
    bank_wdata = '0;
    bank_be    = '0;
    if (!rst_i) begin
      if (bus.cl_wr_req_i) begin
        cl_gnt = 1'b1;
        for (int b = 0; b < NumBanks; b++) begin
          bank_req[b]   = 1'b1;
          bank_we[b]    = 1'b1;
          bank_be[b]    = '1;
          bank_idx[b]   = bus.cl_wr_idx_i;
          bank_wdata[b] = bus.cl_wr_data_i[b];
        end
      end else begin
        for (int b = 0; b < NumBanks; b++) begin
          // A starved word write reserves its bank before any read is considered.
          if (|cand[b] && !(bus.wr_req_i && wr_starve && bus.wr_bank_i == BW'(b))) begin
            win[b]      = rr_pick(cand[b], ptr_q[b]);
            bank_rd[b]  = 1'b1;
            bank_req[b] = 1'b1;
            bank_idx[b] = bus.rd_idx_i[win[b]];
            for (int p = 0; p < NumPorts; p++)
              if (req_b[b][p] && bus.rd_idx_i[p] == bus.rd_idx_i[win[b]]) rd_gnt[p] = 1'b1;
          end
        end
        if (bus.wr_req_i && !bank_rd[bus.wr_bank_i]) begin
          wr_gnt                     = 1'b1;
          bank_req[bus.wr_bank_i]   = 1'b1;
          bank_we[bus.wr_bank_i]    = 1'b1;
          bank_be[bus.wr_bank_i]    = bus.wr_be_i;
          bank_idx[bus.wr_bank_i]   = bus.wr_idx_i;
          bank_wdata[bus.wr_bank_i] = bus.wr_data_i;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int p = 0; p < NumPorts; p++)
      if (rvalid_q[p]) rdata[p] = bus.bank_rdata_i[rbank_q[p]];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q    <= '0;
      cnt_q    <= '0;
      wr_cnt_q <= '0;
      rvalid_q <= '0;
      rbank_q  <= '0;
    end else begin
      for (int b = 0; b < NumBanks; b++)
        if (bank_rd[b]) ptr_q[b] <= (win[b] == PW'(NumPorts - 1)) ? '0 : win[b] + 1'b1;
      for (int p = 0; p < NumPorts; p++) begin
        if (bus.rd_req_i[p] && !rd_gnt[p]) begin
          if (cnt_q[p] != CW'(StarveLimit)) cnt_q[p] <= cnt_q[p] + 1'b1;
        end else begin
          cnt_q[p] <= '0;
        end
        rvalid_q[p] <= rd_gnt[p];
        if (rd_gnt[p]) rbank_q[p] <= bus.rd_bank_i[p];
      end
      if (bus.wr_req_i && !wr_gnt) begin
        if (!wr_starve) wr_cnt_q <= wr_cnt_q + 1'b1;
      end else begin
        wr_cnt_q <= '0;
      end
    end
  end

  assign bus.rd_gnt_o     = rd_gnt;
  assign bus.rd_rvalid_o  = rvalid_q;
  assign bus.rd_rdata_o   = rdata;
  assign bus.cl_wr_gnt_o  = cl_gnt;
  assign bus.wr_gnt_o     = wr_gnt;
  assign bus.bank_req_o   = bank_req;
  assign bus.bank_we_o    = bank_we;
  assign bus.bank_idx_o   = bank_idx;
  assign bus.bank_wdata_o = bank_wdata;
  assign bus.bank_be_o    = bank_be;
endmodule

// File: tb/tb_dcache_bank_arb.sv
// Directed bench for dcache_bank_arb: the read grant patterns, merging, line write,
// starvation escalation for reads and writes, and reset in the middle of a read.
module tb_dcache_bank_arb;
  localparam int NP = 3;
  localparam int NB = 2;
  localparam int IW = 8;
  localparam int WW = 64;
  localparam int SL = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [WW-1:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  dcache_bank_arb_if #(.NumPorts(NP), .NumBanks(NB), .IdxWidth(IW), .WordWidth(WW)) bus ();

  dcache_bank_arb #(
    .NumPorts(NP), .NumBanks(NB), .IdxWidth(IW), .WordWidth(WW), .StarveLimit(SL)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  function automatic logic [WW-1:0] pat(input int b, input logic [IW-1:0] idx);
    return 64'hA5A5_0000_0000_0000 | (64'(b) << 16) | 64'(idx);
  endfunction

  // SRAM model: returns a pattern keyed by bank and index one cycle after a read.
  always @(posedge clk_i)
    for (int b = 0; b < NB; b++)
      if (bus.bank_req_o[b] && !bus.bank_we_o[b]) bus.bank_rdata_i[b] <= pat(b, bus.bank_idx_o[b]);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.rd_req_i     = '0;
    bus.rd_prio_i    = '0;
    bus.rd_bank_i    = '0;
    bus.rd_idx_i     = '0;
    bus.cl_wr_req_i  = 1'b0;
    bus.cl_wr_idx_i  = '0;
    bus.cl_wr_data_i = '0;
    bus.wr_req_i     = 1'b0;
    bus.wr_bank_i    = '0;
    bus.wr_idx_i     = '0;
    bus.wr_data_i    = '0;
    bus.wr_be_i      = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  initial begin
    idle();
    bus.bank_rdata_i = '0;
    // Requests held during reset must see no grants and no bank activity.
    bus.rd_req_i = 3'b111;
    bus.wr_req_i = 1'b1;
    tick();
    check("rst_rd_gnt", 64'(bus.rd_gnt_o), 64'd0);
    check("rst_wr_gnt", 64'(bus.wr_gnt_o), 64'd0);
    check("rst_bank_req", 64'(bus.bank_req_o), 64'd0);
    check("rst_rvalid", 64'(bus.rd_rvalid_o), 64'd0);
    do_reset();

    // Ports 0 and 1 collide on bank 0, and port 2 is alone on bank 1.
    bus.rd_req_i  = 3'b111;
    bus.rd_bank_i = 3'b100;
    bus.rd_idx_i  = {8'd9, 8'd6, 8'd5};
    #1;
    check("b2b_gnt0", 64'(bus.rd_gnt_o), 64'b101);
    check("b2b_bank_req", 64'(bus.bank_req_o), 64'b11);
    check("b2b_bank_we", 64'(bus.bank_we_o), 64'b00);
    check("b2b_idx0", 64'(bus.bank_idx_o[0]), 64'd5);
    check("b2b_idx1", 64'(bus.bank_idx_o[1]), 64'd9);
    exp_q.push_back(pat(0, 8'd5));
    exp_q.push_back(pat(1, 8'd9));
    tick();
    bus.rd_req_i = 3'b011;
    #1;
    check("b2b_rvalid0", 64'(bus.rd_rvalid_o), 64'b101);
    check("b2b_rdata_p0", bus.rd_rdata_o[0], exp_q.pop_front());
    check("b2b_rdata_p2", bus.rd_rdata_o[2], exp_q.pop_front());
    check("b2b_rdata_p1_zero", bus.rd_rdata_o[1], 64'd0);
    check("b2b_gnt1", 64'(bus.rd_gnt_o), 64'b010);
    tick();
    bus.rd_req_i = '0;
    check("b2b_rvalid1", 64'(bus.rd_rvalid_o), 64'b010);
    check("b2b_rdata_p1", bus.rd_rdata_o[1], pat(0, 8'd6));

    // Same bank and same index merge into one access.
    do_reset();
    bus.rd_req_i  = 3'b011;
    bus.rd_bank_i = 3'b000;
    bus.rd_idx_i  = {8'd0, 8'd7, 8'd7};
    #1;
    check("merge_gnt", 64'(bus.rd_gnt_o), 64'b011);
    check("merge_bank_req", 64'(bus.bank_req_o), 64'b01);
    check("unused_bank_be", 64'(bus.bank_be_o[1]), 64'd0);
    tick();
    bus.rd_req_i = '0;
    check("merge_rvalid", 64'(bus.rd_rvalid_o), 64'b011);
    check("merge_rdata0", bus.rd_rdata_o[0], pat(0, 8'd7));
    check("merge_rdata1", bus.rd_rdata_o[1], pat(0, 8'd7));

    // A line write wins over everything else.
    do_reset();
    bus.rd_req_i     = 3'b111;
    bus.rd_bank_i    = 3'b010;
    bus.rd_idx_i     = {8'd1, 8'd2, 8'd3};
    bus.wr_req_i     = 1'b1;
    bus.cl_wr_req_i  = 1'b1;
    bus.cl_wr_idx_i  = 8'd33;
    bus.cl_wr_data_i = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    #1;
    check("cl_gnt", 64'(bus.cl_wr_gnt_o), 64'd1);
    check("cl_bank_we", 64'(bus.bank_we_o), 64'b11);
    check("cl_bank_req", 64'(bus.bank_req_o), 64'b11);
    check("cl_rd_gnt", 64'(bus.rd_gnt_o), 64'd0);
    check("cl_wr_gnt", 64'(bus.wr_gnt_o), 64'd0);
    check("cl_be0", 64'(bus.bank_be_o[0]), 64'hFF);
    check("cl_idx1", 64'(bus.bank_idx_o[1]), 64'd33);
    check("cl_wdata1", bus.bank_wdata_o[1], 64'h1111_2222_3333_4444);
    tick();
    idle();
    check("cl_no_rvalid", 64'(bus.rd_rvalid_o), 64'd0);

    // Port 1 (low priority) starves behind port 0 (high priority) until escalation.
    do_reset();
    bus.rd_req_i  = 3'b011;
    bus.rd_prio_i = 3'b001;
    bus.rd_bank_i = 3'b000;
    bus.rd_idx_i  = {8'd0, 8'd2, 8'd1};
    #1;
    for (int k = 0; k < SL; k++) begin
      check("starve_wait", 64'(bus.rd_gnt_o), 64'b001);
      tick();
    end
    check("starve_escalate", 64'(bus.rd_gnt_o), 64'b010);

    // A word write to bank 1 starves behind continuous reads, then takes the bank.
    do_reset();
    bus.rd_req_i  = 3'b001;
    bus.rd_bank_i = 3'b001;
    bus.rd_idx_i  = {8'd0, 8'd0, 8'd8};
    bus.wr_req_i  = 1'b1;
    bus.wr_bank_i = 1'b1;
    bus.wr_idx_i  = 8'd4;
    bus.wr_data_i = 64'hDEAD_BEEF_0BAD_F00D;
    bus.wr_be_i   = 8'h0F;
    #1;
    for (int k = 0; k < SL; k++) begin
      check("wr_wait_gnt", 64'(bus.wr_gnt_o), 64'd0);
      check("wr_wait_rd", 64'(bus.rd_gnt_o), 64'b001);
      tick();
    end
    check("wr_escalate_gnt", 64'(bus.wr_gnt_o), 64'd1);
    check("wr_escalate_rd", 64'(bus.rd_gnt_o), 64'd0);
    check("wr_bank_we", 64'(bus.bank_we_o), 64'b10);
    check("wr_bank_be", 64'(bus.bank_be_o[1]), 64'h0F);
    check("wr_bank_idx", 64'(bus.bank_idx_o[1]), 64'd4);
    check("wr_bank_wdata", bus.bank_wdata_o[1], 64'hDEAD_BEEF_0BAD_F00D);

    // Reset pulse while a read is being granted.
    do_reset();
    bus.rd_req_i  = 3'b011;
    bus.rd_bank_i = 3'b000;
    bus.rd_idx_i  = {8'd0, 8'd6, 8'd5};
    #1;
    check("mid_gnt_a", 64'(bus.rd_gnt_o), 64'b001);
    tick();
    check("mid_rvalid_a", 64'(bus.rd_rvalid_o), 64'b001);
    check("mid_gnt_b", 64'(bus.rd_gnt_o), 64'b010);
    #1;
    rst_i = 1'b1;
    #1;
    check("mid_rst_gnt", 64'(bus.rd_gnt_o), 64'd0);
    check("mid_rst_rvalid_async", 64'(bus.rd_rvalid_o), 64'd0);
    check("mid_rst_bank_req", 64'(bus.bank_req_o), 64'd0);
    tick();
    check("mid_rst_rvalid_edge", 64'(bus.rd_rvalid_o), 64'd0);
    rst_i = 1'b0;
    #1;
    check("mid_ptr_restart", 64'(bus.rd_gnt_o), 64'b001);
    tick();
    idle();
    check("mid_rdata_after", bus.rd_rdata_o[0], pat(0, 8'd5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_bank_arb.md
DCACHE_BANK_ARB -- requirements
Module: dcache_bank_arb

Interface
REQ-001 SHALL have parameter NumPorts, default 3, number of read ports.
REQ-002 SHALL have parameter NumBanks, default 2, number of data SRAM banks; power of two, at least 2.
REQ-003 SHALL have parameter IdxWidth, default 8, SRAM index width.
REQ-004 SHALL have parameter WordWidth, default 64, bank word width; multiple of 8.
REQ-005 SHALL have parameter StarveLimit, default 8, consecutive ungranted request cycles before escalation; BW = $clog2(NumBanks).
REQ-006 clk_i  in  1  sole clock, rising edge.
REQ-007 rst_i  in  1  asynchronous, active-high reset.
REQ-008 rd_req_i / rd_prio_i / rd_gnt_o  in/in/out  NumPorts  per-port read request, high-priority flag, same-cycle grant.
REQ-009 rd_bank_i / rd_idx_i  in  NumPorts x BW / NumPorts x IdxWidth  per-port bank select and index.
REQ-010 rd_rvalid_o / rd_rdata_o  out  NumPorts / NumPorts x WordWidth  per-port read response.
REQ-011 cl_wr_req_i, cl_wr_idx_i, cl_wr_data_i (NumBanks x WordWidth), cl_wr_gnt_o  full-line write port; bank k takes word k.
REQ-012 wr_req_i, wr_bank_i (BW), wr_idx_i, wr_data_i (WordWidth), wr_be_i (WordWidth/8), wr_gnt_o  single-word write port.
REQ-013 bank_req_o, bank_we_o (NumBanks); bank_idx_o, bank_wdata_o, bank_be_o (per bank); bank_rdata_i (NumBanks x WordWidth, valid one cycle after bank_req_o with bank_we_o=0).

Function
REQ-014 cl_wr_req_i SHALL win unconditionally: cl_wr_gnt_o=1, all banks req=1, we=1, be all-ones, idx=cl_wr_idx_i; all rd_gnt_o and wr_gnt_o = 0.
REQ-015 Effective priority of port p SHALL be rd_prio_i[p] OR starve[p].
REQ-016 Per bank, among requesting ports targeting it, the winner SHALL come from the effective-high set if non-empty, else from all requesters, selected round-robin from that bank's pointer.
REQ-017 Bank pointer SHALL update to (winner+1) mod NumPorts on each read grant in that bank; unchanged otherwise.
REQ-018 Any other port requesting the same bank and same idx as the winner SHALL also be granted (merge) and SHALL NOT move the pointer.
REQ-019 Ports granted in distinct banks SHALL be granted in the same cycle.
REQ-020 wr_gnt_o SHALL be 1 when wr_req_i=1, no cl write, and no read was granted in wr_bank_i; bank driven we=1, be=wr_be_i, idx=wr_idx_i.
REQ-021 If the write starvation counter equals StarveLimit, the word write SHALL take its bank ahead of reads; reads to that bank get no grant that cycle.
REQ-022 Per read port and for the write port, a counter SHALL increment (saturating at StarveLimit) on req AND NOT gnt, and clear on gnt or NOT req; starve = (counter == StarveLimit).
REQ-023 rd_rvalid_o[p] SHALL assert exactly one cycle after rd_gnt_o[p], with rd_rdata_o[p] = bank_rdata_i[registered bank of p]; rd_rdata_o[p] = 0 when rd_rvalid_o[p]=0.
REQ-024 Unused banks SHALL drive req=0, we=0, be=0.
REQ-025 Grants SHALL depend only on current-cycle inputs and registered state (no rd_gnt_o-to-req loops).

Reset
REQ-026 On rst_i, SHALL clear all counters, pointers, registered bank selects, and rd_rvalid_o, asynchronously.
REQ-027 While rst_i is high, all grants and bank_req_o SHALL be 0; a grant in the cycle reset asserts SHALL produce no rvalid.

Verification
REQ-028 Ports 0,1 read bank 0 idx 5/6, port 2 bank 1 -> gnt=3'b101, next cycle rvalid=3'b101; next cycle gnt=3'b010.
REQ-029 Ports 0,1 read bank 0 idx 7 both -> gnt=3'b011 same cycle, both rvalid next cycle with equal data.
REQ-030 cl_wr_req_i with all 3 reads pending -> cl_wr_gnt_o=1, bank_we_o=2'b11, rd_gnt_o=0.
REQ-031 StarveLimit=4, port 1 low prio vs port 0 high prio continuously on bank 0 -> port 1 ungranted 4 cycles, granted 5th cycle.
REQ-032 Word write bank 1 with continuous port 0 reads to bank 1 -> wr_gnt_o=0 for StarveLimit cycles, then 1 with rd_gnt_o[0]=0.
REQ-033 rst_i pulse mid-read -> rd_rvalid_o=0 next edge; pointers and counters restart at 0.
